// File: rtl/dds_lut_pkg.sv
// Shared types and helpers for the DDS waveform look-up table and its users.
package dds_lut_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } ld_state_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Cycles from PHASE/RD_EN sampling to DO/DO_VALID; DDS top aligns its valids with this.
  function automatic int unsigned read_latency(input int unsigned out_reg);
    return 32'd1 + out_reg;
  endfunction

endpackage

// File: rtl/dds_wave_lut_ram_if.sv
// Load-stream and read-port bundle between the host/phase logic and the waveform table.
interface dds_wave_lut_ram_if #(
  parameter int DATA_W = 18,
  parameter int PH_W   = 9
);
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              table_valid;
  logic              rd_en;
  logic [PH_W-1:0]   phase;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;

  modport master (
    output ld_start, ld_valid, ld_data, rd_en, phase,
    input  ld_ready, ld_done, table_valid, dout, dout_valid
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, rd_en, phase,
    output ld_ready, ld_done, table_valid, dout, dout_valid
  );
endinterface

// File: rtl/dds_lut_tpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module dds_lut_tpram #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: no reset on the array or the read register; a reset term prevents block-RAM mapping.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/dds_wave_lut_ram.sv
// Waveform look-up table with streaming loader, optional quarter-wave rebuild and output stage.
module dds_wave_lut_ram
  import dds_lut_pkg::*;
#(
  parameter int  DATA_W       = 18,
  parameter int  ADDR_W       = 9,
  parameter int  QUARTER_WAVE = 0,
  parameter int  OUT_REG      = 1,
  localparam int PH_W         = ADDR_W + 2 * QUARTER_WAVE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dds_wave_lut_ram_if.slave  bus
);
  ld_state_e         r_state, w_nxt_state;
  logic [ADDR_W-1:0] r_wptr, w_nxt_wptr;
  logic              w_we, w_last, w_clr_tv;
  logic              r_ld_done, r_table_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_wptr  = r_wptr;
    w_we        = 1'b0;
    w_last      = 1'b0;
    w_clr_tv    = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.ld_start) begin
        w_nxt_state = ST_LOAD;
        w_nxt_wptr  = '0;
        w_clr_tv    = 1'b1;
      end
      ST_LOAD: if (bus.ld_start) begin
        w_nxt_wptr = '0;
        w_clr_tv   = 1'b1;
      end else if (bus.ld_valid) begin
        w_we       = 1'b1;
        w_nxt_wptr = r_wptr + 1'b1;
        if (&r_wptr) begin
          w_nxt_state = ST_IDLE;
          w_last      = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_wptr        <= '0;
      r_ld_done     <= 1'b0;
      r_table_valid <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_wptr    <= w_nxt_wptr;
      r_ld_done <= w_last;
      if (w_last)        r_table_valid <= 1'b1;
      else if (w_clr_tv) r_table_valid <= 1'b0;
    end
  end

  assign bus.ld_ready    = (r_state == ST_LOAD);
  assign bus.ld_done     = r_ld_done;
  assign bus.table_valid = r_table_valid;

  logic [ADDR_W-1:0] w_raddr;
  logic              w_neg;

  generate
    if (QUARTER_WAVE != 0) begin : g_quarter
      logic [1:0] w_quad;
      assign w_quad  = bus.phase[PH_W-1 -: 2];
      // Odd quadrants walk the quarter table backwards; the upper half is the negated image.
      assign w_raddr = (w_quad == QUAD_1 || w_quad == QUAD_3) ? ~bus.phase[ADDR_W-1:0]
                                                              :  bus.phase[ADDR_W-1:0];
      assign w_neg   = (w_quad == QUAD_2 || w_quad == QUAD_3);
    end else begin : g_full
      assign w_raddr = bus.phase[ADDR_W-1:0];
      assign w_neg   = 1'b0;
    end
  endgenerate

  logic [DATA_W-1:0] w_rdata;

  dds_lut_tpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (bus.ld_data),
    .i_re    (bus.rd_en),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Sign and zero flags travel with the RAM read; zero resets high so DO reads 0 out of reset.
  logic              r_s1_valid, r_s1_neg, r_s1_zero;
  logic [DATA_W-1:0] w_s1_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_neg   <= 1'b0;
      r_s1_zero  <= 1'b1;
    end else begin
      r_s1_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_s1_neg  <= w_neg;
        r_s1_zero <= ~r_table_valid;
      end
    end
  end

  assign w_s1_data = r_s1_zero ? '0 : (r_s1_neg ? -w_rdata : w_rdata);

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] r_do;
      logic              r_do_valid;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_do       <= '0;
          r_do_valid <= 1'b0;
        end else begin
          r_do_valid <= r_s1_valid;
          if (r_s1_valid) r_do <= w_s1_data;
        end
      end
      assign bus.dout       = r_do;
      assign bus.dout_valid = r_do_valid;
    end else begin : g_nooreg
      assign bus.dout       = w_s1_data;
      assign bus.dout_valid = r_s1_valid;
    end
  endgenerate
endmodule

// File: tb/tb_dds_wave_lut_ram.sv
// Bench for dds_wave_lut_ram: full-table instances at both output latencies plus a quarter-wave one.
module tb_dds_wave_lut_ram;
  import dds_lut_pkg::*;

  localparam int DW = 18, AW = 9, DEPTH = 512;
  localparam int QDW = 8, QAW = 4, QPW = 6, QDEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_wave_lut_ram_if #(.DATA_W(DW),  .PH_W(AW))  bus_a ();
  dds_wave_lut_ram_if #(.DATA_W(DW),  .PH_W(AW))  bus_b ();
  dds_wave_lut_ram_if #(.DATA_W(QDW), .PH_W(QPW)) bus_q ();

  logic          ld_start, ld_valid, rd_en;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] phase;
  logic           q_ld_start, q_ld_valid, q_rd_en;
  logic [QDW-1:0] q_ld_data;
  logic [QPW-1:0] q_phase;

  assign bus_a.ld_start = ld_start;  assign bus_b.ld_start = ld_start;
  assign bus_a.ld_valid = ld_valid;  assign bus_b.ld_valid = ld_valid;
  assign bus_a.ld_data  = ld_data;   assign bus_b.ld_data  = ld_data;
  assign bus_a.rd_en    = rd_en;     assign bus_b.rd_en    = rd_en;
  assign bus_a.phase    = phase;     assign bus_b.phase    = phase;
  assign bus_q.ld_start = q_ld_start;
  assign bus_q.ld_valid = q_ld_valid;
  assign bus_q.ld_data  = q_ld_data;
  assign bus_q.rd_en    = q_rd_en;
  assign bus_q.phase    = q_phase;

  dds_wave_lut_ram #(.OUT_REG(1)) u_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
  dds_wave_lut_ram #(.OUT_REG(0)) u_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));
  dds_wave_lut_ram #(.DATA_W(QDW), .ADDR_W(QAW), .QUARTER_WAVE(1), .OUT_REG(1))
    u_q (.i_clk(clk), .i_rst(rst), .bus(bus_q));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model of the full-table instances: table contents, load progress, and
  // a two-deep history of sampled reads that feeds the 1- and 2-cycle outputs.
  int  mdl_mem [DEPTH];
  bit  m_loading, m_tv, m_done;
  int  m_wptr;
  bit  h0_v, h1_v;
  int  h0_val, h1_val;
  bit  exp_v_a, exp_v_b;
  int  exp_dout_a, exp_dout_b;
  bit  nv;
  int  nval;

  always @(posedge clk) begin
    nv   = !rst && rd_en;
    nval = m_tv ? mdl_mem[phase] : 0;
    if (rst) begin
      m_loading = 0; m_wptr = 0; m_tv = 0; m_done = 0;
      h0_v = 0; h1_v = 0;
      exp_v_a = 0; exp_v_b = 0; exp_dout_a = 0; exp_dout_b = 0;
    end else begin
      m_done = 0;
      if (ld_start) begin
        m_loading = 1; m_wptr = 0; m_tv = 0;
      end else if (m_loading && ld_valid) begin
        mdl_mem[m_wptr] = int'(ld_data);
        if (m_wptr == DEPTH - 1) begin
          m_loading = 0; m_tv = 1; m_done = 1; m_wptr = 0;
        end else m_wptr++;
      end
      h1_v = h0_v; h1_val = h0_val;
      h0_v = nv;   h0_val = nval;
      exp_v_b = h0_v; if (h0_v) exp_dout_b = h0_val;
      exp_v_a = h1_v; if (h1_v) exp_dout_a = h1_val;
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_ld_ready",    32'(bus_a.ld_ready),    32'(m_loading));
      check("a_ld_done",     32'(bus_a.ld_done),     32'(m_done));
      check("a_table_valid", 32'(bus_a.table_valid), 32'(m_tv));
      check("a_do_valid",    32'(bus_a.dout_valid),  32'(exp_v_a));
      check("a_do",          32'(bus_a.dout),        32'(exp_dout_a[DW-1:0]));
      check("b_table_valid", 32'(bus_b.table_valid), 32'(m_tv));
      check("b_do_valid",    32'(bus_b.dout_valid),  32'(exp_v_b));
      check("b_do",          32'(bus_b.dout),        32'(exp_dout_b[DW-1:0]));
    end
  end

  int qmem [QDEPTH];

  function automatic logic [QDW-1:0] q_model(input int p);
    int quad = p / QDEPTH;
    int idx  = p % QDEPTH;
    int w    = qmem[(quad % 2 == 1) ? (QDEPTH - 1 - idx) : idx];
    if (quad >= 2) w = -w;
    return QDW'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic q_read(input logic [QPW-1:0] p, output logic [QDW-1:0] d);
    q_rd_en = 1'b1; q_phase = p; tick();
    q_rd_en = 1'b0; tick();
    check("q_do_valid", 32'(bus_q.dout_valid), 32'd1);
    d = bus_q.dout;
  endtask

  task automatic readback_all();
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; phase = AW'(i); tick();
    end
    rd_en = 1'b0; tick(); tick();
  endtask

  int done_cnt;
  logic [DW-1:0]  tmp_d;
  logic [QDW-1:0] qd;

  initial begin
    rst = 1'b1;
    ld_start = 0; ld_valid = 0; rd_en = 0; ld_data = '0; phase = '0;
    q_ld_start = 0; q_ld_valid = 0; q_rd_en = 0; q_ld_data = '0; q_phase = '0;
    repeat (3) tick();
    check("rst_do",          32'(bus_a.dout),        32'd0);
    check("rst_do_valid",    32'(bus_a.dout_valid),  32'd0);
    check("rst_ld_ready",    32'(bus_a.ld_ready),    32'd0);
    check("rst_ld_done",     32'(bus_a.ld_done),     32'd0);
    check("rst_table_valid", 32'(bus_a.table_valid), 32'd0);
    check("rst_b_do",        32'(bus_b.dout),        32'd0);
    cmp_en = 1;
    rst = 1'b0;
    tick();

    // Read before any load: zero data, valid still follows RD_EN.
    rd_en = 1'b1; phase = AW'(5); tick();
    rd_en = 1'b0; tick();
    check("preload_do_valid", 32'(bus_a.dout_valid), 32'd1);
    check("preload_do",       32'(bus_a.dout),       32'd0);

    // Full load with data = address, idle gaps, and one read mid-load.
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = '1; tick();
    ld_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; ld_data = DW'(i); rd_en = (i == 300); phase = AW'(5); tick();
      if (i % 37 == 36) begin
        ld_valid = 1'b0; rd_en = 1'b0; tick();
      end
    end
    check("load_done_pulse",  32'(bus_a.ld_done),     32'd1);
    check("load_table_valid", 32'(bus_a.table_valid), 32'd1);
    ld_valid = 1'b0; rd_en = 1'b0;
    tick();
    check("load_done_single", 32'(bus_a.ld_done), 32'd0);
    readback_all();
    check("readback_last", 32'(bus_a.dout), 32'd511);

    // Same read into both instances: OUT_REG=0 answers one cycle earlier.
    rd_en = 1'b1; phase = AW'(5); tick();
    rd_en = 1'b0;
    check("lat0_valid", 32'(bus_b.dout_valid), 32'd1);
    check("lat0_do",    32'(bus_b.dout),       32'd5);
    check("lat1_early", 32'(bus_a.dout_valid), 32'd0);
    tick();
    check("lat1_valid", 32'(bus_a.dout_valid), 32'd1);
    check("lat1_do",    32'(bus_a.dout),       32'd5);

    // Restart after 100 beats, then a full load of ~address.
    done_cnt = 0;
    ld_start = 1'b1; tick();
    ld_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ld_valid = 1'b1; ld_data = DW'($urandom); tick();
      done_cnt += int'(bus_a.ld_done);
    end
    ld_start = 1'b1; ld_data = DW'(18'h155); tick();
    ld_start = 1'b0;
    done_cnt += int'(bus_a.ld_done);
    for (int i = 0; i < DEPTH; i++) begin
      tmp_d = DW'(i);
      ld_valid = 1'b1; ld_data = ~tmp_d; tick();
      done_cnt += int'(bus_a.ld_done);
    end
    ld_valid = 1'b0; tick();
    done_cnt += int'(bus_a.ld_done);
    check("restart_done_pulses", 32'(done_cnt), 32'd1);
    readback_all();
    check("restart_last", 32'(bus_a.dout), 32'h3FE00);

    // Reset at beat 200 with a read issued every cycle.
    ld_start = 1'b1; tick();
    ld_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      ld_valid = 1'b1; ld_data = DW'(i); rd_en = 1'b1; phase = AW'(i); tick();
    end
    rst = 1'b1; tick();
    check("midrst_do_valid",    32'(bus_a.dout_valid),  32'd0);
    check("midrst_b_do_valid",  32'(bus_b.dout_valid),  32'd0);
    check("midrst_do",          32'(bus_a.dout),        32'd0);
    check("midrst_ld_ready",    32'(bus_a.ld_ready),    32'd0);
    check("midrst_table_valid", 32'(bus_a.table_valid), 32'd0);
    rst = 1'b0; rd_en = 1'b0;
    repeat (20) tick();
    check("post_rst_ld_ready",    32'(bus_a.ld_ready),    32'd0);
    check("post_rst_table_valid", 32'(bus_a.table_valid), 32'd0);
    ld_valid = 1'b0;

    // Reset wins over a coincident LD_START.
    rst = 1'b1; ld_start = 1'b1; tick();
    rst = 1'b0; ld_start = 1'b0; tick();
    check("rst_wins_ld_ready", 32'(bus_a.ld_ready), 32'd0);

    // Quarter-wave instance: 16-entry table, mem[i] = i+1.
    q_ld_start = 1'b1; tick();
    q_ld_start = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      q_ld_valid = 1'b1; q_ld_data = QDW'(i + 1); qmem[i] = i + 1; tick();
    end
    q_ld_valid = 1'b0;
    check("q_ld_done",     32'(bus_q.ld_done),     32'd1);
    check("q_table_valid", 32'(bus_q.table_valid), 32'd1);
    q_read(6'h03, qd); check("q_p03", 32'(qd), 32'h04);
    q_read(6'h13, qd); check("q_p13", 32'(qd), 32'h0D);
    q_read(6'h23, qd); check("q_p23", 32'(qd), 32'hFC);
    q_read(6'h33, qd); check("q_p33", 32'(qd), 32'hF3);
    for (int p = 0; p < 4 * QDEPTH; p++) begin
      q_read(QPW'(p), qd);
      check("q_sweep", 32'(qd), 32'(q_model(p)));
    end

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
